// File: rtl/conway_grid_stepper_if.sv
// Board loader / stepper / readback bundle for conway_grid_stepper.
// The master side drives requests and the readback index; the slave side is the engine.
interface conway_grid_stepper_if #(
  parameter int COLS  = 8,
  parameter int ROWS  = 8,
  parameter int GEN_W = 16
);
  localparam int RW = $clog2(ROWS);

  logic             load_valid;
  logic             load_ready;
  logic [RW-1:0]    load_row;
  logic [COLS-1:0]  load_data;

  logic             step_valid;
  logic             step_ready;
  logic [GEN_W-1:0] step_count;

  logic             busy;
  logic             done;
  logic [GEN_W-1:0] generation;

  logic [RW-1:0]    rd_row;
  logic [COLS-1:0]  rd_data;

  modport master (
    output load_valid, load_row, load_data,
    output step_valid, step_count,
    output rd_row,
    input  load_ready, step_ready, busy, done, generation, rd_data
  );

  modport slave (
    input  load_valid, load_row, load_data,
    input  step_valid, step_count,
    input  rd_row,
    output load_ready, step_ready, busy, done, generation, rd_data
  );
endinterface

// File: rtl/conway_grid_stepper.sv
// Row-sequential Game of Life engine: one board row is rewritten per clock while running.
// Define CONWAY_TORUS_WRAP_EN to make the board a torus; otherwise off-board cells are dead.
module conway_grid_stepper #(
  parameter int COLS  = 8,
  parameter int ROWS  = 8,
  parameter int GEN_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  conway_grid_stepper_if.slave bus
);
  localparam int              RW       = $clog2(ROWS);
  localparam logic [RW-1:0]   LAST_ROW = RW'(ROWS - 1);
  localparam logic [RW:0]     ROWS_LIM = (RW + 1)'(ROWS);
  localparam logic [GEN_W-1:0] ONE_GEN = GEN_W'(1);

`ifdef CONWAY_TORUS_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FINISH
  } state_t;

  state_t state_reg, state_next;

  logic [COLS-1:0]  board_reg [ROWS];
  logic [RW-1:0]    row_reg;
  logic [GEN_W-1:0] remaining_reg;
  logic [GEN_W-1:0] generation_reg;
  logic [COLS-1:0]  above_reg;
  logic [COLS-1:0]  row0_reg;
  logic [COLS-1:0]  rd_data_reg;

  logic             busy;
  logic             load_fire;
  logic             step_fire;
  logic             step_nonzero;
  logic             load_hit;
  logic             rd_hit;
  logic             last_row;
  logic [RW-1:0]    below_idx;
  logic [COLS-1:0]  above_row;
  logic [COLS-1:0]  cur_row;
  logic [COLS-1:0]  below_row;
  logic [COLS-1:0]  new_row;

  // ---------------------------------------------------------------------------
  // Handshake and status
  // ---------------------------------------------------------------------------
  assign busy         = (state_reg == ST_RUN);
  assign load_fire    = bus.load_valid && !busy;
  assign step_fire    = bus.step_valid && !busy;
  assign step_nonzero = (bus.step_count != '0);
  assign load_hit     = ({1'b0, bus.load_row} < ROWS_LIM);
  assign rd_hit       = ({1'b0, bus.rd_row} < ROWS_LIM);
  assign last_row     = (row_reg == LAST_ROW);
  assign below_idx    = last_row ? '0 : row_reg + 1'b1;

  assign bus.load_ready = !busy;
  assign bus.step_ready = !busy;
  assign bus.busy       = busy;
  assign bus.done       = (state_reg == ST_FINISH);
  assign bus.generation = generation_reg;
  assign bus.rd_data    = rd_data_reg;

  // ---------------------------------------------------------------------------
  // Row window: rows above r are already rewritten, so "above" comes from the
  // saved original; row 0's original is kept aside to serve as "below" of the last row.
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_row   = board_reg[row_reg];
    above_row = above_reg;
    below_row = board_reg[below_idx];
    if (row_reg == '0) begin
      above_row = WRAP_EN ? board_reg[LAST_ROW] : '0;
    end
    if (last_row) begin
      below_row = WRAP_EN ? row0_reg : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-column rule datapath, shared by every row
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    localparam int LEFT  = (gi == 0) ? COLS - 1 : gi - 1;
    localparam int RIGHT = (gi == COLS - 1) ? 0 : gi + 1;
    localparam bit L_EN  = (gi != 0) || WRAP_EN;
    localparam bit R_EN  = (gi != COLS - 1) || WRAP_EN;

    logic       a_l, a_c, a_r;
    logic       m_l, m_r;
    logic       b_l, b_c, b_r;
    logic [3:0] count;

    assign a_l = L_EN & above_row[LEFT];
    assign a_c = above_row[gi];
    assign a_r = R_EN & above_row[RIGHT];
    assign m_l = L_EN & cur_row[LEFT];
    assign m_r = R_EN & cur_row[RIGHT];
    assign b_l = L_EN & below_row[LEFT];
    assign b_c = below_row[gi];
    assign b_r = R_EN & below_row[RIGHT];

    assign count = {3'b000, a_l} + {3'b000, a_c} + {3'b000, a_r}
                 + {3'b000, m_l} + {3'b000, m_r}
                 + {3'b000, b_l} + {3'b000, b_c} + {3'b000, b_r};

    assign new_row[gi] = (count == 4'd3) || (cur_row[gi] && (count == 4'd2));
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      // FINISH is not busy, so a step offered there is accepted and started
      // rather than silently dropped.
      ST_IDLE, ST_FINISH: begin
        state_next = ST_IDLE;
        if (step_fire) begin
          state_next = step_nonzero ? ST_RUN : ST_FINISH;
        end
      end
      ST_RUN: begin
        if (last_row && (remaining_reg == ONE_GEN)) begin
          state_next = ST_FINISH;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Board, counters and readback
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        board_reg[r] <= '0;
      end
      row_reg        <= '0;
      remaining_reg  <= '0;
      generation_reg <= '0;
      above_reg      <= '0;
      row0_reg       <= '0;
      rd_data_reg    <= '0;
    end else begin
      if (load_fire && load_hit) begin
        board_reg[bus.load_row] <= bus.load_data;
      end

      if (step_fire && step_nonzero) begin
        remaining_reg <= bus.step_count;
        row_reg       <= '0;
      end

      if (busy) begin
        board_reg[row_reg] <= new_row;
        above_reg          <= cur_row;
        if (row_reg == '0) begin
          row0_reg <= cur_row;
        end
        if (last_row) begin
          generation_reg <= generation_reg + ONE_GEN;
          remaining_reg  <= remaining_reg - ONE_GEN;
          row_reg        <= '0;
        end else begin
          row_reg <= row_reg + 1'b1;
        end
      end

      rd_data_reg <= rd_hit ? board_reg[bus.rd_row] : '0;
    end
  end

endmodule

// File: doc/conway_grid_stepper.md
# conway_grid_stepper

Parametrised Game of Life engine holding a ROWS x COLS board in registers and advancing it a requested number of generations. It replaces the single-cell combinational evaluator with a row-sequential engine: one board row is updated per clock, so an 8-cell-wide rule datapath is shared across all rows. The block sits between the board loader and the display/readback path of the Conway core.

## Interface
- COLS, default 8: cells per row (at least 3).
- ROWS, default 8: rows in the board (at least 3).
- GEN_W, default 16: width of the generation counter and the step count.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_valid  in  1  row-write request.
- load_ready  out  1  high when a row write is accepted; equals !busy.
- load_row  in  $clog2(ROWS)  index of the row to write.
- load_data  in  COLS  row contents; bit c is column c; 1 = alive.
- step_valid  in  1  run request.
- step_ready  out  1  equals !busy.
- step_count  in  GEN_W  number of generations to run.
- busy  out  1  high while the FSM is in RUN.
- done  out  1  one-cycle pulse when a run completes.
- generation  out  GEN_W  total generations computed since reset; wraps modulo 2^GEN_W.
- rd_row  in  $clog2(ROWS)  readback row index.
- rd_data  out  COLS  registered readback of board[rd_row].

## Operation
- The clock is one port and the reset is asynchronous, active-low.
- Reset values:
  - board all 0.
  - FSM in IDLE.
  - busy, done and generation at 0.
  - rd_data 0.
  - The remaining-generation counter, row index and saved-row registers at 0.
- Cell rule: the next state is alive if exactly 3 of the 8 neighbours are alive, or if the cell is alive and exactly 2 neighbours are alive. Every other case gives dead.
- FSM states are IDLE, RUN and FINISH.
  - IDLE → RUN: step accepted with step_count ≠ 0. Loads remaining = step_count and row = 0.
  - IDLE → FINISH: step accepted with step_count = 0. The board is unchanged.
  - RUN: each cycle computes the new row r from three inputs: the saved original of row r−1 ("above"), board[r], and board[r+1] ("below").
    - It writes the result into board[r].
    - It saves the old board[r] as the next "above".
  - Row 0 "above" is the original of row ROWS−1 when wrapping is enabled, otherwise all-zero. Row 0's original is also saved in a dedicated register, used as "below" for row ROWS−1.
  - At row ROWS−1, generation increments and remaining decrements. If remaining reaches 0, go to FINISH; otherwise row returns to 0.
  - FINISH: done = 1 for exactly one cycle, then IDLE.
- Row load: accepted when load_valid && load_ready. Writes board[load_row] = load_data.
  - Writes with load_row ≥ ROWS are accepted and ignored.
  - Loads do not alter generation.
- Load and step in the same cycle: the load is committed at that edge, and the run uses the loaded data.
- While busy, load_valid and step_valid are ignored (ready is low). Requests are not queued.
- Column edges follow the same wrap or zero rule as the row edges.
- rd_data returns the row at any time. During RUN it shows the partially updated board.

## Timing
- A step accepted at edge T with N ≥ 1 generations:
  - busy is high from T+1 through T+N·ROWS.
  - done is high in cycle T+N·ROWS+1.
  - step_ready rises in cycle T+N·ROWS+1.
- A step with N = 0: done is high in cycle T+1, and busy stays low.
- One generation takes exactly ROWS cycles. generation updates on the edge that writes row ROWS−1.
- rd_data latency is 1 cycle: rd_row sampled at edge T appears after T.
- rst_n assertion mid-run immediately clears the board, the FSM, busy, done and generation. No done pulse is produced.

## Configuration
- CONWAY_TORUS_WRAP_EN defined: the board is a torus. The row above row 0 is row ROWS−1, the row below row ROWS−1 is row 0, and column −1/COLS maps to COLS−1/0.
- CONWAY_TORUS_WRAP_EN undefined: all cells outside the board read as dead.

## Test plan
- Blinker (8x8, rows 3..5 col 4 set, N=1) → row 4 = 8'b0011_1000, rows 3 and 5 = 0. done at T+9, generation = 1.
- Block still life (cols 2..3, rows 2..3, N=5) → board unchanged, generation = 5, busy high for exactly 40 cycles.
- N=0 step → done at T+1, busy never high, board and generation unchanged.
- Glider crossing the bottom-right corner, N=4:
  - with CONWAY_TORUS_WRAP_EN the glider reappears shifted by (+1,+1) modulo 8.
  - without it the edge-clipped pattern matches a golden model with dead borders.
- load_valid and step_valid pulsed mid-run → both ignored (ready low). Board matches the uninterrupted result.
- rst_n low for one cycle at T+3 of a run → busy = 0, done never pulses, all rows read 0, generation = 0.
